// File: rtl/uart_rx_fifo.sv
`default_nettype none
//============================================================================
// Module   : uart_rx_fifo
// Purpose  : Receive-side byte buffer behind uart_rx. Captures each byte on
//            wr_tick, presents the oldest byte show-ahead on rd_data, and
//            reports occupancy, empty/full and almost-full for flow control.
// Options  : UART_RX_FIFO_OVERRUN_EN - adds the sticky overrun flag and its
//            overrun_clr input; without it, dropped writes are silent.
// Revision : 1.0 - initial release
//============================================================================
module uart_rx_fifo #(
    parameter int DATA_SIZE  = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
`ifdef UART_RX_FIFO_OVERRUN_EN
    input  logic                  overrun_clr,
    output logic                  overrun,
`endif
    input  logic                  wr_tick,
    input  logic [DATA_SIZE-1:0]  wr_data,
    input  logic                  rd_en,
    output logic [DATA_SIZE-1:0]  rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int              c_depth     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_af_thresh = AF_THRESH[ADDR_WIDTH:0];

    logic [DATA_SIZE-1:0] r_mem [c_depth];
    logic [ADDR_WIDTH:0]  r_wr_ptr;
    logic [ADDR_WIDTH:0]  r_rd_ptr;
    logic [ADDR_WIDTH:0]  w_count;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;

    // Occupancy and status are derived directly from the wrap-bit pointers.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

    // A pop needs data present; a push into a full FIFO is allowed only when
    // the same cycle frees a slot (when full, the FIFO cannot be empty).
    assign w_pop  = rd_en && !w_empty;
    assign w_push = wr_tick && (!w_full || w_pop);

    assign rd_data     = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (w_count >= c_af_thresh);
    assign count       = w_count;

    // Storage array: contents are never reset, only written on accepted pushes.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Pointer advance; the extra MSB wraps naturally and disambiguates full/empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic r_overrun;
    logic w_drop;

    assign w_drop  = wr_tick && w_full && !rd_en;
    assign overrun = r_overrun;

    // Sticky overrun: a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
//============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo against a queue-based
//            reference model; directed scenarios followed by random traffic.
// Revision : 1.0 - initial release
//============================================================================
module tb_uart_rx_fifo;

    localparam int c_depth = 16;
    localparam int c_af    = 14;

    logic       clk;
    logic       reset_n;
    logic       wr_tick;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
`ifdef UART_RX_FIFO_OVERRUN_EN
    logic       overrun;
    logic       overrun_clr;
`endif

    uart_rx_fifo #(
        .DATA_SIZE  (8),
        .ADDR_WIDTH (4),
        .AF_THRESH  (c_af)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
`ifdef UART_RX_FIFO_OVERRUN_EN
        .overrun_clr (overrun_clr),
        .overrun     (overrun),
`endif
        .wr_tick     (wr_tick),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_q[$];
    logic       m_overrun = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the reference queue.
    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'(m_q.size()));
        check({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
        check({tag, ".full"},  32'(full),  32'(m_q.size() == c_depth));
        check({tag, ".af"},    32'(almost_full), 32'(m_q.size() >= c_af));
        if (m_q.size() != 0) check({tag, ".rd_data"}, 32'(rd_data), 32'(m_q[0]));
`ifdef UART_RX_FIFO_OVERRUN_EN
        check({tag, ".overrun"}, 32'(overrun), 32'(m_overrun));
`endif
    endtask

    // One clock with the given strobes; the model applies the FIFO's rules
    // to the occupancy seen before the edge.
    task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                        input logic clr, input string tag);
        bit do_pop;
        bit do_push;
        wr_tick = wr;
        wr_data = d;
        rd_en   = rd;
`ifdef UART_RX_FIFO_OVERRUN_EN
        overrun_clr = clr;
`endif
        @(posedge clk);
        #1;
        do_pop  = rd && (m_q.size() > 0);
        do_push = wr && ((m_q.size() < c_depth) || do_pop);
        if (wr && !do_push) m_overrun = 1'b1;
        else if (clr) m_overrun = 1'b0;
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(d);
        wr_tick = 1'b0;
        rd_en   = 1'b0;
`ifdef UART_RX_FIFO_OVERRUN_EN
        overrun_clr = 1'b0;
`endif
        check_state(tag);
    endtask

    initial begin
        wr_tick = 1'b0;
        wr_data = 8'h00;
        rd_en   = 1'b0;
`ifdef UART_RX_FIFO_OVERRUN_EN
        overrun_clr = 1'b0;
`endif
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_state("reset");

        // Asynchronous reset with three bytes queued.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "pre_rst");
        #2;
        reset_n = 1'b0;
        #1;
        m_q.delete();
        m_overrun = 1'b0;
        check_state("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_state("rst_release");

        // Single byte, then pop; a pop on empty is ignored.
        step(1'b1, 8'hCD, 1'b0, 1'b0, "single");
        step(1'b0, 8'h00, 1'b1, 1'b0, "single_pop");
        step(1'b0, 8'h00, 1'b1, 1'b0, "pop_empty");

        // Fill 0x00..0x0F, then overflow with 0xAA.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        step(1'b1, 8'hAA, 1'b0, 1'b0, "overflow");
        step(1'b0, 8'h00, 1'b0, 1'b1, "ovr_clr");

        // Simultaneous push/pop at full; 0x55 must come out last.
        step(1'b1, 8'h55, 1'b1, 1'b0, "full_pushpop");
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");

        // Simultaneous push/pop at empty: push only.
        step(1'b1, 8'h33, 1'b1, 1'b0, "empty_pushpop");
        step(1'b0, 8'h00, 1'b1, 1'b0, "empty_pop33");

        // 40 interleaved push/pop pairs with random data.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "wrap_push");
            step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_pop");
        end

        // Random traffic, biased to visit both full and empty repeatedly.
        for (int i = 0; i < 600; i++) begin
            int  bias;
            logic w;
            logic r;
            bias = (i / 100) % 2;
            w = ($urandom_range(0, 99) < (bias ? 75 : 35));
            r = ($urandom_range(0, 99) < (bias ? 35 : 75));
            step(w, 8'($urandom_range(0, 255)), r,
                 logic'($urandom_range(0, 9) == 0), "random");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
